acr_packet_decoder: RTL and testbench

Sink-side HDMI Audio Clock Regeneration (ACR) block, in the `clk_pixel` domain behind the data-island packet decoder.
- Accepts decoded data-island packets and filters ACR packets (HB0 = 0x01).
- Validates and extracts N and CTS, and qualifies lock.
- Regenerates the audio clock as clock-enable pulses at 128·fs (average rate f_pixel·N/CTS) and fs, for the audio sample FIFO and I2S/PWM output stages.

---
 rtl/acr_packet_decoder.sv | 143 ++++++++++++++
 tb/tb_acr_packet_decoder.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/acr_packet_decoder.sv
// HDMI sink Audio Clock Regeneration: filters ACR packets, qualifies N/CTS lock,
// and regenerates 128*fs and fs clock enables in the pixel clock domain.
module acr_packet_decoder #(
    parameter int LOCK_COUNT     = 2,
    parameter int CTS_TOLERANCE  = 16,
    parameter int TIMEOUT_CYCLES = 2_000_000
) (
    input  logic             clk_pixel,
    input  logic             reset,
    input  logic             packet_strobe,
    input  logic [23:0]      header,
    input  logic [3:0][55:0] sub,
    output logic [19:0]      n_value,
    output logic [19:0]      cts_value,
    output logic             locked,
    output logic             audio_clk_en,
    output logic             sample_en,
    output logic             packet_error
);
    localparam int MW = $clog2(LOCK_COUNT + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [MW-1:0] LC_LAST  = MW'(LOCK_COUNT - 1);
    localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [19:0]   TOL      = 20'(CTS_TOLERANCE);

    typedef enum logic [1:0] {UNLOCKED, ACQUIRE, LOCKED} state_t;

    state_t        state_q, state_d;
    logic [19:0]   n_q, n_d, cts_q, cts_d;
    logic [MW-1:0] cnt_q, cnt_d;
    logic [TW-1:0] to_q, to_d;
    logic [20:0]   acc_q, acc_d;
    logic [6:0]    div_q, div_d;
    logic          ace_q, ace_d, se_q, se_d, err_q, err_d;

    logic [19:0] pkt_n, pkt_cts, cts_diff;
    logic        is_acr, pkt_ok, in_tol, run;
    logic [20:0] sum;
    logic        unused_hb;

    assign unused_hb = ^header[23:8];
    assign pkt_n     = {sub[0][35:32], sub[0][47:40], sub[0][55:48]};
    assign pkt_cts   = {sub[0][11:8],  sub[0][23:16], sub[0][31:24]};
    assign is_acr    = packet_strobe && (header[7:0] == 8'h01);
    // Subpackets are compared first, so reserved bits need checking in sub[0] only
    assign pkt_ok    = (sub[1] == sub[0]) && (sub[2] == sub[0]) && (sub[3] == sub[0]) &&
                       (sub[0][39:36] == 4'h0) && (sub[0][15:12] == 4'h0) &&
                       (sub[0][7:0] == 8'h00) && (pkt_n != 20'h0) && (pkt_cts != 20'h0) &&
                       (pkt_n < pkt_cts);
    assign cts_diff  = (pkt_cts >= cts_q) ? pkt_cts - cts_q : cts_q - pkt_cts;
    assign in_tol    = (pkt_n == n_q) && (cts_diff <= TOL);

    always_comb begin
        state_d = state_q;
        n_d     = n_q;
        cts_d   = cts_q;
        cnt_d   = cnt_q;
        to_d    = to_q + TW'(1);
        err_d   = 1'b0;
        if (is_acr) begin
            to_d = '0;
            if (!pkt_ok) begin
                err_d   = 1'b1;
                state_d = UNLOCKED;
                cnt_d   = '0;
            end else if (state_q == UNLOCKED) begin
                n_d     = pkt_n;
                cts_d   = pkt_cts;
                cnt_d   = MW'(1);
                state_d = (LOCK_COUNT <= 1) ? LOCKED : ACQUIRE;
            end else if (in_tol) begin
                cts_d = pkt_cts;
                if (cnt_q <= LC_LAST) cnt_d = cnt_q + MW'(1);
                if (cnt_q >= LC_LAST) state_d = LOCKED;
            end else begin
                n_d     = pkt_n;
                cts_d   = pkt_cts;
                cnt_d   = MW'(1);
                state_d = ACQUIRE;
            end
        end else if (to_q == TO_LAST) begin
            to_d    = '0;
            state_d = UNLOCKED;
            n_d     = '0;
            cts_d   = '0;
            cnt_d   = '0;
        end
    end

    // Regeneration runs only while staying in LOCKED, so any exit clears acc/divider
    assign run = (state_q == LOCKED) && (state_d == LOCKED);
    assign sum = acc_q + {1'b0, n_q};

    always_comb begin
        acc_d = '0;
        div_d = '0;
        ace_d = 1'b0;
        se_d  = 1'b0;
        if (run) begin
            acc_d = sum;
            div_d = div_q;
            if (sum >= {1'b0, cts_q}) begin
                acc_d = sum - {1'b0, cts_q};
                ace_d = 1'b1;
                div_d = div_q + 7'd1;
                se_d  = (div_q == 7'd127);
            end
        end
    end

    always_ff @(posedge clk_pixel) begin
        if (reset) begin
            state_q <= UNLOCKED;
            n_q     <= '0;
            cts_q   <= '0;
            cnt_q   <= '0;
            to_q    <= '0;
            acc_q   <= '0;
            div_q   <= '0;
            ace_q   <= 1'b0;
            se_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            cts_q   <= cts_d;
            cnt_q   <= cnt_d;
            to_q    <= to_d;
            acc_q   <= acc_d;
            div_q   <= div_d;
            ace_q   <= ace_d;
            se_q    <= se_d;
            err_q   <= err_d;
        end
    end

    assign n_value      = n_q;
    assign cts_value    = cts_q;
    assign locked       = (state_q == LOCKED);
    assign audio_clk_en = ace_q;
    assign sample_en    = se_q;
    assign packet_error = err_q;
endmodule

// File: tb/tb_acr_packet_decoder.sv
// Randomized and directed bench for acr_packet_decoder against a cycle-level
// reference model of the lock rules and N/CTS regeneration arithmetic.
module tb_acr_packet_decoder;
    localparam int LC  = 2;
    localparam int TOL = 16;
    localparam int TO  = 1000;

    logic             clk_pixel = 1'b0;
    logic             reset = 1'b1;
    logic             packet_strobe = 1'b0;
    logic [23:0]      header = '0;
    logic [3:0][55:0] sub = '0;
    logic [19:0]      n_value, cts_value;
    logic             locked, audio_clk_en, sample_en, packet_error;

    acr_packet_decoder #(.LOCK_COUNT(LC), .CTS_TOLERANCE(TOL), .TIMEOUT_CYCLES(TO)) dut (
        .clk_pixel(clk_pixel), .reset(reset), .packet_strobe(packet_strobe),
        .header(header), .sub(sub), .n_value(n_value), .cts_value(cts_value),
        .locked(locked), .audio_clk_en(audio_clk_en), .sample_en(sample_en),
        .packet_error(packet_error));

    always #5 clk_pixel = ~clk_pixel;

    int n_cmp = 0, n_err = 0;
    int ace_cnt = 0, se_cnt = 0;

    // model: m_st 0 = unlocked, 1 = acquiring, 2 = locked
    int     m_st = 0, m_cnt = 0, m_n = 0, m_cts = 0, m_idle = 0, m_div = 0;
    longint m_acc = 0;
    bit     e_ace = 0, e_se = 0, e_err = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [55:0] mk(input int n, input int c);
        logic [55:0] s;
        logic [19:0] nn, cc;
        nn = n[19:0];
        cc = c[19:0];
        s = '0;
        s[55:48] = nn[7:0];  s[47:40] = nn[15:8];  s[35:32] = nn[19:16];
        s[31:24] = cc[7:0];  s[23:16] = cc[15:8];  s[11:8]  = cc[19:16];
        return s;
    endfunction

    task automatic model_step();
        int  pn, pc, d, st0, on0, oc0;
        bit  ok;
        if (reset) begin
            m_st = 0; m_cnt = 0; m_n = 0; m_cts = 0; m_idle = 0; m_div = 0; m_acc = 0;
            e_ace = 0; e_se = 0; e_err = 0;
            return;
        end
        st0 = m_st; on0 = m_n; oc0 = m_cts;
        e_err = 0;
        pn = int'({sub[0][35:32], sub[0][47:40], sub[0][55:48]});
        pc = int'({sub[0][11:8], sub[0][23:16], sub[0][31:24]});
        ok = (sub[1] == sub[0]) && (sub[2] == sub[0]) && (sub[3] == sub[0]) &&
             ((sub[0] & 56'h0000_F000_00F0_FF) == 56'h0) && pn > 0 && pc > 0 && pn < pc;
        if (packet_strobe && header[7:0] == 8'h01) begin
            m_idle = 0;
            d = pc - m_cts;
            if (d < 0) d = -d;
            if (!ok) begin
                e_err = 1; m_st = 0; m_cnt = 0;
            end else if (m_st == 0) begin
                m_n = pn; m_cts = pc; m_cnt = 1; m_st = (LC <= 1) ? 2 : 1;
            end else if (pn == m_n && d <= TOL) begin
                m_cts = pc;
                if (m_cnt < LC) m_cnt++;
                if (m_cnt >= LC) m_st = 2;
            end else begin
                m_n = pn; m_cts = pc; m_cnt = 1; m_st = 1;
            end
        end else begin
            m_idle++;
            if (m_idle == TO) begin
                m_idle = 0; m_st = 0; m_n = 0; m_cts = 0; m_cnt = 0;
            end
        end
        if (st0 == 2 && m_st == 2) begin
            m_acc += on0;
            e_ace = (m_acc >= oc0);
            e_se  = 0;
            if (e_ace) begin
                m_acc -= oc0;
                m_div = (m_div + 1) % 128;
                e_se  = (m_div == 0);
            end
        end else begin
            m_acc = 0; m_div = 0; e_ace = 0; e_se = 0;
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk_pixel);
        #1;
        chk("locked", locked, m_st == 2);
        chk("n_value", n_value, m_n);
        chk("cts_value", cts_value, m_cts);
        chk("packet_error", packet_error, e_err);
        chk("audio_clk_en", audio_clk_en, e_ace);
        chk("sample_en", sample_en, e_se);
        ace_cnt += int'(audio_clk_en);
        se_cnt  += int'(sample_en);
        packet_strobe = 1'b0;
        reset = 1'b0;
    endtask

    task automatic idle(input int k);
        for (int i = 0; i < k; i++) tick();
    endtask

    task automatic send(input logic [7:0] hb0, input logic [55:0] s0, input logic [55:0] s1,
                        input logic [55:0] s2, input logic [55:0] s3);
        header = {16'($urandom()), hb0};
        sub[0] = s0; sub[1] = s1; sub[2] = s2; sub[3] = s3;
        packet_strobe = 1'b1;
        tick();
    endtask

    task automatic send_acr(input int n, input int c);
        logic [55:0] s;
        s = mk(n, c);
        send(8'h01, s, s, s, s);
    endtask

    task automatic send_other();
        logic [7:0] hb;
        hb = ($urandom_range(0, 1) == 0) ? 8'h02 : 8'($urandom_range(2, 255));
        send(hb, {24'($urandom()), 32'($urandom())}, {24'($urandom()), 32'($urandom())},
             {24'($urandom()), 32'($urandom())}, {24'($urandom()), 32'($urandom())});
    endtask

    task automatic relock(input int n, input int c);
        send_acr(n, c);
        idle(3);
        send_acr(n, c);
    endtask

    initial begin
        logic [55:0] g, b;
        int r, c, n;

        // reset state
        idle(2);
        chk("rst_locked", locked, 0);
        chk("rst_n", n_value, 0);
        chk("rst_err", packet_error, 0);

        // two packets 10 cycles apart, then one CTS period of pulses
        send_acr(6144, 25200);
        chk("t1_not_yet", locked, 0);
        idle(9);
        send_acr(6144, 25200);
        chk("t1_locked", locked, 1);
        ace_cnt = 0; se_cnt = 0;
        for (int i = 1; i <= 25200; i++) begin
            if (i % 500 == 0) send_acr(6144, 25200);
            else tick();
        end
        chk("t1_ace_count", ace_cnt, 6144);
        chk("t1_se_count", se_cnt, 48);

        // in-tolerance update keeps lock; out-of-tolerance drops to acquire
        send_acr(6144, 25210);
        chk("t2_tol_locked", locked, 1);
        chk("t2_tol_cts", cts_value, 25210);
        idle(40);
        send_acr(6144, 25300);
        chk("t2_oot_unlocked", locked, 0);
        idle(5);
        send_acr(6144, 25300);
        chk("t2_relocked", locked, 1);
        idle(100);

        // rejected packets
        for (int k = 0; k < 3; k++) begin
            relock(6144, 25200);
            idle(60);
            g = mk(6144, 25200);
            ace_cnt = 0;
            if (k == 0) begin
                b = g ^ (56'h1 << $urandom_range(0, 55));
                send(8'h01, g, g, b, g);
            end else if (k == 1) begin
                b = g | 56'h01;
                send(8'h01, b, b, b, b);
            end else begin
                send_acr(30000, 25200);
            end
            chk("t3_error", packet_error, 1);
            chk("t3_unlocked", locked, 0);
            idle(200);
            chk("t3_no_clk", ace_cnt, 0);
        end

        // non-ACR packets interleaved while locked
        relock(6144, 25200);
        for (int i = 0; i < 3000; i++) begin
            r = $urandom_range(0, 99);
            if (r < 10) send_other();
            else if (r < 13) send_acr(6144, 25200);
            else tick();
        end
        chk("t4_locked", locked, 1);
        chk("t4_n", n_value, 6144);

        // timeout
        relock(6144, 25200);
        idle(TO - 1);
        chk("t5_before_to", locked, 1);
        idle(1);
        chk("t5_to_unlocked", locked, 0);
        chk("t5_to_n", n_value, 0);
        chk("t5_to_cts", cts_value, 0);
        ace_cnt = 0;
        idle(200);
        chk("t5_no_clk", ace_cnt, 0);

        // reset with a coincident strobe
        relock(6144, 25200);
        idle(300);
        g = mk(4096, 27000);
        header = 24'h000001;
        sub[0] = g; sub[1] = g; sub[2] = g; sub[3] = g;
        packet_strobe = 1'b1;
        reset = 1'b1;
        tick();
        chk("t6_rst_locked", locked, 0);
        chk("t6_rst_ace", audio_clk_en, 0);
        tick();
        chk("t6_ignored_n", n_value, 0);
        chk("t6_ignored_cts", cts_value, 0);

        // mixed random traffic, including jitter, new rates, bad packets and resets
        relock(6144, 25200);
        c = 25200; n = 6144;
        for (int i = 0; i < 5000; i++) begin
            r = $urandom_range(0, 999);
            if (r < 2) begin
                reset = 1'b1;
                tick();
            end else if (r < 60) send_other();
            else if (r < 110) send_acr(n, c);
            else if (r < 140) begin
                c = c + $urandom_range(0, 40) - 20;
                send_acr(n, c);
            end else if (r < 145) begin
                c = $urandom_range(2000, 30000);
                n = $urandom_range(1, c - 1);
                send_acr(n, c);
            end else if (r < 150) begin
                g = mk(n, c);
                b = g ^ (56'h1 << $urandom_range(0, 55));
                send(8'h01, b, b, b, g);
            end else tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
